fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 empty  input  1  FIFO empty flag.
REQ-005 fifo_data  input  WIDTH  FIFO read data, valid the cycle after an accepted rd_en.
REQ-006 rd_en  output  1  FIFO pop request.
REQ-007 m_valid  output  1  stream data valid.
REQ-008 m_ready  input  1  downstream accepts the current word.
REQ-009 m_data  output  WIDTH  stream data word.
REQ-010 rd_count  output  16  number of words delivered; present only with FIFO_RDR_STATS_EN.

Function
REQ-011 The block SHALL buffer up to 2 FIFO words in order, with occupancy states S_EMPTY, S_ONE, S_TWO.
REQ-012 inflight SHALL be a 1-bit register that is set in the cycle after rd_en=1 and cleared otherwise.
REQ-013 rd_en SHALL equal !rst && !empty && (occ + inflight - (m_valid && m_ready)) < 2; the combinational path from m_ready is intended.
REQ-014 rd_en SHALL never assert while empty=1, so the FIFO is never underflowed.
REQ-015 When inflight=1, fifo_data SHALL be captured into the buffer at tail position occ, adjusted for a same-cycle pop.
REQ-016 m_valid SHALL equal (occ != 0); m_data SHALL be the head entry.
REQ-017 m_data SHALL be held stable while m_valid && !m_ready.
REQ-018 A transfer occurs when m_valid && m_ready; the head is removed and the second entry, if any, becomes the head the next cycle.
REQ-019 A simultaneous capture and pop SHALL leave occ unchanged and preserve order.
REQ-020 Throughput: with empty=0 and m_ready=1 continuously, the block SHALL deliver 1 word/cycle after an initial 2-cycle latency (rd_en -> capture -> m_valid).
REQ-021 The occupancy transitions SHALL be:
- S_EMPTY->S_ONE on capture.
- S_ONE->S_TWO on capture without pop.
- S_ONE->S_EMPTY on pop without capture.
- S_TWO->S_ONE on pop.
REQ-022 A capture in S_TWO without a pop is impossible by REQ-013; the verification engineer SHALL assert that it never occurs.
REQ-023 Words SHALL exit in exactly FIFO pop order, with no loss or duplication.

Reset
REQ-024 While rst=1, the block SHALL force rd_en=0, m_valid=0, m_data=0, occ=S_EMPTY, inflight=0 and rd_count=0.
REQ-025 On reset mid-operation, buffered words SHALL be discarded.
REQ-026 fifo_data returning in the cycle after rst rises SHALL be ignored.
REQ-027 The first rd_en after reset SHALL occur no earlier than the first cycle with rst=0.

Configuration
REQ-028 Macro FIFO_RDR_STATS_EN SHALL control the rd_count feature.
- Defined: rd_count increments by 1 on each transfer and wraps 0xFFFF->0x0000.
- Undefined: the rd_count port and counter logic are absent; all other behaviour is identical.

Structure
REQ-029 Package fifo_pkg SHALL hold the occupancy state typedef (S_EMPTY, S_ONE, S_TWO), the default WIDTH constant, and the constant SKID_DEPTH=2.
REQ-030 The 2-entry ordered buffer SHALL be a sub-module fifo_rdr_skid with ports push, pop, din, dout and occupancy.
REQ-031 fifo_stream_reader SHALL own the rd_en/inflight control logic.

Verification
REQ-032 Scenario 1: FIFO preloaded with 0x11, 0x22, 0x33 and m_ready=1 -> rd_en at cycles 0-2, m_valid cycles 2-4, m_data 0x11, 0x22, 0x33, then empty=1 with no further rd_en.
REQ-033 Scenario 2: 4 words preloaded and m_ready=0 -> exactly 2 rd_en pulses, m_valid=1, m_data=first word held stable; releasing m_ready delivers all 4 in order.
REQ-034 Scenario 3: empty=1 for 10 cycles -> rd_en=0 and m_valid=0 throughout.
REQ-035 Scenario 4: m_ready toggling 1,0,1,0 over a 16-word stream 0x00..0x0F -> output sequence 0x00..0x0F with no gaps or duplicates, and m_data stable on every stalled cycle.
REQ-036 Scenario 5: rst asserted one cycle after rd_en, with 1 word buffered -> next cycle m_valid=0, occ=S_EMPTY; the returning fifo_data is dropped; after rst falls, the next word popped is the first one delivered.
REQ-037 Scenario 6 (FIFO_RDR_STATS_EN): 65537 transfers -> rd_count=0x0001; after rst, rd_count=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and constants for the FIFO stream reader.
//   occ_t         - skid buffer occupancy state (S_EMPTY, S_ONE, S_TWO)
//   WIDTH_DEFAULT - default data word width
//   SKID_DEPTH    - number of words the skid buffer holds
package fifo_pkg;
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} occ_t;
    localparam int WIDTH_DEFAULT = 8;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/fifo_rdr_skid.sv
// fifo_rdr_skid: two-entry ordered buffer between the FIFO read port and the stream.
//   clk, rst  - clock, synchronous active-high reset
//   push, din - write din at the tail
//   pop       - remove the head (ignored when empty)
//   dout      - head entry
//   occupancy - number of stored words as occ_t
module fifo_rdr_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output occ_t             occupancy
);
    occ_t occ, occ_nx;
    logic [WIDTH-1:0] head, tail, head_nx, tail_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= S_EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            occ  <= occ_nx;
            head <= head_nx;
            tail <= tail_nx;
        end
    end

    // A push in S_TWO without a pop cannot happen: the reader never has more
    // words outstanding than free slots, so that case simply holds.
    always_comb begin
        occ_nx  = occ;
        head_nx = head;
        tail_nx = tail;
        case (occ)
            S_EMPTY: if (push) begin
                head_nx = din;
                occ_nx  = S_ONE;
            end
            S_ONE: if (push && pop) head_nx = din;
            else if (push) begin
                tail_nx = din;
                occ_nx  = S_TWO;
            end else if (pop) occ_nx = S_EMPTY;
            S_TWO: if (pop) begin
                head_nx = tail;
                if (push) tail_nx = din;
                else occ_nx = S_ONE;
            end
            default: occ_nx = S_EMPTY;
        endcase
    end

    assign dout      = head;
    assign occupancy = occ;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a first-word-fall-through-less FIFO and presents a valid/ready stream.
//   clk, rst   - clock, synchronous active-high reset
//   empty      - FIFO empty flag
//   fifo_data  - FIFO read data, valid the cycle after rd_en
//   rd_en      - FIFO pop request
//   m_valid, m_ready, m_data - output stream
//   rd_count   - delivered word count, only when FIFO_RDR_STATS_EN is defined
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef FIFO_RDR_STATS_EN
    ,
    output logic [15:0]      rd_count
`endif
);
    occ_t occ;
    logic inflight, xfer;
    logic [WIDTH-1:0] head;
    logic [2:0] level;

    assign m_valid = !rst && occ != S_EMPTY;
    assign m_data  = m_valid ? head : '0;
    assign xfer    = m_valid && m_ready;
    // Words held plus the one in flight, minus the one leaving this cycle.
    assign level   = {1'b0, occ} + {2'b0, inflight} - {2'b0, xfer};
    assign rd_en   = !rst && !empty && level < 3'(SKID_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) inflight <= 1'b0;
        else inflight <= rd_en;
    end

    fifo_rdr_skid #(.WIDTH(WIDTH)) u_skid (
        .clk(clk),
        .rst(rst),
        .push(inflight),
        .pop(xfer),
        .din(fifo_data),
        .dout(head),
        .occupancy(occ)
    );

`ifdef FIFO_RDR_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) rd_count <= '0;
        else if (xfer) rd_count <= rd_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed vector table plus FIFO-model sequences for fifo_stream_reader.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    logic clk = 1'b0, rst = 1'b1, empty = 1'b1, m_ready = 1'b0;
    logic [7:0] fifo_data = 8'h00;
    logic rd_en, m_valid;
    logic [7:0] m_data;
`ifdef FIFO_RDR_STATS_EN
    logic [15:0] rd_count;
`endif
    int checks = 0, errors = 0;

    fifo_stream_reader #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .empty(empty),
        .fifo_data(fifo_data),
        .rd_en(rd_en),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data)
`ifdef FIFO_RDR_STATS_EN
        ,
        .rd_count(rd_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && dut.u_skid.occupancy == S_TWO && dut.u_skid.push && !dut.u_skid.pop) begin
            errors++;
            $display("FAIL overfill: push into full buffer without pop at %0t", $time);
        end

    typedef struct {
        string name;
        logic r, e, rdy;
        logic [7:0] d;
        logic x_rd, x_valid;
        logic [7:0] x_data;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input string n, input logic r, e, rdy, input logic [7:0] d,
                       input logic x_rd, x_valid, input logic [7:0] x_data);
        vec_t v;
        v.name = n; v.r = r; v.e = e; v.rdy = rdy; v.d = d;
        v.x_rd = x_rd; v.x_valid = x_valid; v.x_data = x_data;
        vecs.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    logic [7:0] fq[$], exp_q[$];
    logic [7:0] rdata, held;
    logic stalled;
    int delivered, pulses;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; empty = 1'b1; m_ready = 1'b0; fifo_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        fq.delete(); exp_q.delete();
        rdata = 8'h00; stalled = 1'b0; delivered = 0; pulses = 0;
    endtask

    task automatic cyc(input logic rdy);
        @(negedge clk);
        empty = (fq.size() == 0);
        m_ready = rdy;
        fifo_data = rdata;
        #1;
        chk("no_underflow", rd_en && empty, 0);
        if (rd_en) pulses++;
        if (stalled) chk("stall_stable", m_data, held);
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("extra_word", m_data, 32'hFFFF_FFFF);
            else chk("order", m_data, exp_q.pop_front());
            delivered++;
        end
        stalled = m_valid && !m_ready;
        held = m_data;
        rdata = (rd_en && fq.size() != 0) ? fq.pop_front() : 8'h00;
    endtask

    initial begin
        add("reset",  1, 0, 1, 8'h00, 0, 0, 8'h00);
        add("s1_c0",  0, 0, 1, 8'h00, 1, 0, 8'h00);
        add("s1_c1",  0, 0, 1, 8'h11, 1, 0, 8'h00);
        add("s1_c2",  0, 0, 1, 8'h22, 1, 1, 8'h11);
        add("s1_c3",  0, 1, 1, 8'h33, 0, 1, 8'h22);
        add("s1_c4",  0, 1, 1, 8'h00, 0, 1, 8'h33);
        add("s1_c5",  0, 1, 1, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) add("s3_empty", 0, 1, 1, 8'h00, 0, 0, 8'h00);
        add("s5_d0",  0, 0, 0, 8'h00, 1, 0, 8'h00);
        add("s5_d1",  0, 0, 0, 8'hA1, 1, 0, 8'h00);
        add("s5_rst", 1, 0, 0, 8'hB2, 0, 0, 8'h00);
        add("s5_d3",  0, 0, 1, 8'h00, 1, 0, 8'h00);
        add("s5_d4",  0, 0, 1, 8'hC3, 1, 0, 8'h00);
        add("s5_d5",  0, 1, 1, 8'hD4, 0, 1, 8'hC3);
        add("s5_d6",  0, 1, 1, 8'h00, 0, 1, 8'hD4);
        add("s5_d7",  0, 1, 1, 8'h00, 0, 0, 8'h00);

        repeat (2) @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].r; empty = vecs[i].e; m_ready = vecs[i].rdy; fifo_data = vecs[i].d;
            #1;
            chk({vecs[i].name, ".rd_en"}, rd_en, vecs[i].x_rd);
            chk({vecs[i].name, ".m_valid"}, m_valid, vecs[i].x_valid);
            if (vecs[i].x_valid || vecs[i].r) chk({vecs[i].name, ".m_data"}, m_data, vecs[i].x_data);
        end

        do_reset();
        for (int i = 0; i < 4; i++) begin
            fq.push_back(8'h40 + 8'(i));
            exp_q.push_back(8'h40 + 8'(i));
        end
        repeat (8) cyc(1'b0);
        chk("s2_pulses", pulses, 2);
        chk("s2_valid", m_valid, 1);
        chk("s2_head", m_data, 8'h40);
        for (int c = 0; c < 20 && delivered < 4; c++) cyc(1'b1);
        chk("s2_delivered", delivered, 4);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            fq.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        for (int c = 0; c < 200 && delivered < 16; c++) cyc(c % 2 == 0);
        chk("s4_delivered", delivered, 16);
        repeat (4) cyc(1'b1);
        chk("s4_drained", m_valid, 0);
        chk("s4_no_extra", delivered, 16);

`ifdef FIFO_RDR_STATS_EN
        do_reset();
        chk("s6_reset", rd_count, 0);
        begin
            int total = 0;
            for (int c = 0; c < 70000 && total < 65537; c++) begin
                @(negedge clk);
                empty = 1'b0; m_ready = 1'b1; fifo_data = 8'h5A;
                #1;
                if (m_valid && m_ready) total++;
            end
            @(negedge clk);
            m_ready = 1'b0; empty = 1'b1;
            #1;
            chk("s6_transfers", total, 65537);
            chk("s6_wrap", rd_count, 16'h0001);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("s6_after_rst", rd_count, 0);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
